// File: rtl/hs_update_ctrl.sv
// High-score table update sequencer: keeps an external RAM sorted (descending) and inserts the
// final score on entry to the DONE game state. Optional table clear is enabled by HS_CLEAR_EN.
module hs_update_ctrl #(
    parameter  int DEPTH   = 4,
    parameter  int SCORE_W = 32,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [2:0]         state,
    input  logic [SCORE_W-1:0] score,
`ifdef HS_CLEAR_EN
    input  logic               clear,
`endif
    input  logic [ADDR_W-1:0]  disp_addr,
    output logic [SCORE_W-1:0] disp_data,
    output logic               disp_stall,
    output logic [ADDR_W-1:0]  ram_rd_addr,
    input  logic [SCORE_W-1:0] ram_rd_data,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_wr_addr,
    output logic [SCORE_W-1:0] ram_wr_data,
    output logic               busy,
    output logic               done,
    output logic               qualified,
    output logic [ADDR_W-1:0]  new_rank
);

    localparam int               CNT_W   = ADDR_W + 1;
    localparam logic [2:0]       GS_DONE = 3'b011;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SCAN_RD,
        SCAN_CMP,
        SHIFT_RD,
        SHIFT_WR,
        INSERT,
        FINISH
`ifdef HS_CLEAR_EN
        , CLEAR
`endif
    } fsm_t;

    fsm_t               fsm, fsm_next;
    logic [2:0]         prev_state;
    logic [SCORE_W-1:0] latched, latched_next;
    logic [CNT_W-1:0]   i, i_next;
    logic [ADDR_W-1:0]  p, p_next;
    logic [ADDR_W-1:0]  j, j_next;
    logic               qual_r, qual_next;
    logic [ADDR_W-1:0]  rank_r, rank_next;
    logic               trigger;
    logic [CNT_W-1:0]   i_inc;
    logic [ADDR_W-1:0]  j_dec;

    // Only a fresh entry into DONE starts an update; holding DONE does not retrigger.
    assign trigger = (state == GS_DONE) && (prev_state != GS_DONE);
    assign i_inc   = i + 1'b1;
    assign j_dec   = j - 1'b1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsm        <= IDLE;
            prev_state <= 3'b000;
            latched    <= '0;
            i          <= '0;
            p          <= '0;
            j          <= '0;
            qual_r     <= 1'b0;
            rank_r     <= '0;
        end else begin
            fsm        <= fsm_next;
            prev_state <= state;
            latched    <= latched_next;
            i          <= i_next;
            p          <= p_next;
            j          <= j_next;
            qual_r     <= qual_next;
            rank_r     <= rank_next;
        end
    end

    always_comb begin
        fsm_next     = fsm;
        latched_next = latched;
        i_next       = i;
        p_next       = p;
        j_next       = j;
        qual_next    = qual_r;
        rank_next    = rank_r;
        ram_rd_addr  = i[ADDR_W-1:0];
        ram_we       = 1'b0;
        ram_wr_addr  = '0;
        ram_wr_data  = '0;
        busy         = 1'b1;
        done         = 1'b0;

        case (fsm)
            IDLE: begin
                busy        = 1'b0;
                ram_rd_addr = disp_addr;
                if (trigger) begin
                    latched_next = score;
                    i_next       = '0;
                    fsm_next     = SCAN_RD;
                end
`ifdef HS_CLEAR_EN
                else if (clear) begin
                    i_next   = '0;
                    fsm_next = CLEAR;
                end
`endif
            end
            SCAN_RD: begin
                fsm_next = SCAN_CMP;
            end
            SCAN_CMP: begin
                // Strictly greater: an equal score never displaces the earlier holder.
                if (latched > ram_rd_data) begin
                    p_next   = i[ADDR_W-1:0];
                    j_next   = LAST;
                    fsm_next = (LAST > i[ADDR_W-1:0]) ? SHIFT_RD : INSERT;
                end else begin
                    i_next = i_inc;
                    if (i_inc == CNT_END) begin
                        qual_next = 1'b0;
                        fsm_next  = FINISH;
                    end else begin
                        fsm_next = SCAN_RD;
                    end
                end
            end
            SHIFT_RD: begin
                ram_rd_addr = j_dec;
                fsm_next    = SHIFT_WR;
            end
            SHIFT_WR: begin
                ram_we      = 1'b1;
                ram_wr_addr = j;
                ram_wr_data = ram_rd_data;
                j_next      = j_dec;
                fsm_next    = (j_dec > p) ? SHIFT_RD : INSERT;
            end
            INSERT: begin
                ram_we      = 1'b1;
                ram_wr_addr = p;
                ram_wr_data = latched;
                qual_next   = 1'b1;
                rank_next   = p;
                fsm_next    = FINISH;
            end
            FINISH: begin
                done     = 1'b1;
                fsm_next = IDLE;
            end
`ifdef HS_CLEAR_EN
            CLEAR: begin
                ram_we      = 1'b1;
                ram_wr_addr = i[ADDR_W-1:0];
                ram_wr_data = '0;
                i_next      = i_inc;
                if (i_inc == CNT_END) begin
                    qual_next = 1'b0;
                    fsm_next  = FINISH;
                end
            end
`endif
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    assign disp_data  = ram_rd_data;
    assign disp_stall = busy;
    assign qualified  = qual_r;
    assign new_rank   = rank_r;

endmodule

// File: tb/tb_hs_update_ctrl.sv
// Directed bench for hs_update_ctrl: table-driven update vectors against a behavioural RAM,
// plus hand-written sequences for display reads, held DONE, mid-update reset and optional clear.
module tb_hs_update_ctrl;

    localparam int DEPTH   = 4;
    localparam int SCORE_W = 32;
    localparam int ADDR_W  = 2;

    typedef logic [DEPTH-1:0][SCORE_W-1:0] tbl_t;

    typedef struct {
        tbl_t               init;
        logic [SCORE_W-1:0] score;
        tbl_t               exp;
        logic               exp_qual;
        int                 exp_rank;
        int                 exp_busy;
        int                 exp_writes;
    } vec_t;

    logic               Clk = 1'b0;
    logic               Reset_n;
    logic [2:0]         state;
    logic [SCORE_W-1:0] score;
`ifdef HS_CLEAR_EN
    logic               clear;
`endif
    logic [ADDR_W-1:0]  disp_addr;
    logic [SCORE_W-1:0] disp_data;
    logic               disp_stall;
    logic [ADDR_W-1:0]  ram_rd_addr;
    logic [SCORE_W-1:0] ram_rd_data;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_wr_addr;
    logic [SCORE_W-1:0] ram_wr_data;
    logic               busy;
    logic               done;
    logic               qualified;
    logic [ADDR_W-1:0]  new_rank;

    logic [SCORE_W-1:0] mem [DEPTH];
    logic               load_en;
    logic [ADDR_W-1:0]  load_addr;
    logic [SCORE_W-1:0] load_data;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    hs_update_ctrl #(.DEPTH(DEPTH), .SCORE_W(SCORE_W)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .state       (state),
        .score       (score),
`ifdef HS_CLEAR_EN
        .clear       (clear),
`endif
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .disp_stall  (disp_stall),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .ram_we      (ram_we),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .busy        (busy),
        .done        (done),
        .qualified   (qualified),
        .new_rank    (new_rank)
    );

    always #5 Clk = ~Clk;

    // Synchronous RAM with one-cycle read latency; the bench preloads it through load_en.
    always @(posedge Clk) begin
        if (load_en)
            mem[load_addr] <= load_data;
        else if (ram_we)
            mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic tbl_t tbl(input logic [31:0] a0, a1, a2, a3);
        tbl_t t;
        t[0] = a0;
        t[1] = a1;
        t[2] = a2;
        t[3] = a3;
        return t;
    endfunction

    task automatic add_vec(input tbl_t init, input logic [31:0] sc, input tbl_t exp,
                           input logic q, input int r, input int b, input int w);
        vec_t v;
        v.init       = init;
        v.score      = sc;
        v.exp        = exp;
        v.exp_qual   = q;
        v.exp_rank   = r;
        v.exp_busy   = b;
        v.exp_writes = w;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load_table(input tbl_t t);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge Clk);
            load_en   = 1'b1;
            load_addr = ADDR_W'(k);
            load_data = t[k];
        end
        @(negedge Clk);
        load_en = 1'b0;
    endtask

    task automatic check_table(input string tag, input tbl_t exp);
        for (int k = 0; k < DEPTH; k++)
            checkOutput($sformatf("%s ram[%0d]", tag, k), 64'(mem[k]), 64'(exp[k]));
    endtask

    // Enters DONE once and records busy length, done position and write count.
    task automatic applyStimulus(input logic [SCORE_W-1:0] sc, output int busy_cnt,
                                 output int done_at, output int done_cnt, output int we_cnt);
        bit finished;
        busy_cnt = 0;
        done_at  = -1;
        done_cnt = 0;
        we_cnt   = 0;
        finished = 1'b0;
        @(negedge Clk);
        score = sc;
        state = 3'b011;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            disp_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            if (done) begin
                done_cnt++;
                if (busy) done_at = busy_cnt + 1;
            end
            if (ram_we) we_cnt++;
            if (busy) begin
                busy_cnt++;
            end else begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) checkOutput("update timeout", 64'd0, 64'd1);
        state = 3'b000;
        @(negedge Clk);
    endtask

    task automatic check_update(input string tag, input vec_t v, input int busy_cnt,
                                input int done_at, input int done_cnt, input int we_cnt);
        checkOutput({tag, " busy cycles"}, 64'(busy_cnt), 64'(v.exp_busy));
        checkOutput({tag, " done pulses"}, 64'(done_cnt), 64'd1);
        checkOutput({tag, " done position"}, 64'(done_at), 64'(v.exp_busy));
        checkOutput({tag, " writes"}, 64'(we_cnt), 64'(v.exp_writes));
        checkOutput({tag, " qualified"}, 64'(qualified), 64'(v.exp_qual));
        checkOutput({tag, " new_rank"}, 64'(new_rank), 64'(v.exp_rank));
        check_table(tag, v.exp);
    endtask

    initial begin
        int   bc, da, dc, wc, starts, dones;
        logic prev_busy;
        tbl_t base;

        base = tbl(900, 500, 300, 100);
        add_vec(base, 400,  tbl(900, 500, 400, 300),  1'b1, 2, 10, 2);
        add_vec(base, 50,   base,                     1'b0, 2, 9,  0);
        add_vec(base, 300,  tbl(900, 500, 300, 300),  1'b1, 3, 10, 1);
        add_vec(base, 1000, tbl(1000, 900, 500, 300), 1'b1, 0, 10, 4);
        add_vec(tbl(0, 0, 0, 0), 0, tbl(0, 0, 0, 0),  1'b0, 0, 9,  0);
        add_vec(tbl(100, 80, 60, 40), 70, tbl(100, 80, 70, 60), 1'b1, 2, 10, 2);
        add_vec(tbl(32'h8000_0000, 3, 2, 1), 2, tbl(32'h8000_0000, 3, 2, 2), 1'b1, 3, 10, 1);
        add_vec(tbl(7, 7, 7, 7), 7, tbl(7, 7, 7, 7),  1'b0, 3, 9,  0);
        add_vec(tbl(7, 7, 7, 7), 8, tbl(8, 7, 7, 7),  1'b1, 0, 10, 4);

        Reset_n   = 1'b1;
        state     = 3'b000;
        score     = '0;
        disp_addr = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
`ifdef HS_CLEAR_EN
        clear     = 1'b0;
`endif
        #2 Reset_n = 1'b0;
        #21;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset ram_we", 64'(ram_we), 64'd0);
        checkOutput("reset qualified", 64'(qualified), 64'd0);
        checkOutput("reset new_rank", 64'(new_rank), 64'd0);
        checkOutput("reset ram_wr_addr", 64'(ram_wr_addr), 64'd0);
        checkOutput("reset ram_wr_data", 64'(ram_wr_data), 64'd0);
        checkOutput("reset disp_stall", 64'(disp_stall), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Idle display pass-through with one-cycle read latency.
        load_table(base);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge Clk);
            disp_addr = ADDR_W'(k);
            @(negedge Clk);
            checkOutput($sformatf("disp_data[%0d]", k), 64'(disp_data), 64'(base[k]));
            checkOutput("idle disp_stall", 64'(disp_stall), 64'd0);
        end

        foreach (vecs[n]) begin
            load_table(vecs[n].init);
            applyStimulus(vecs[n].score, bc, da, dc, wc);
            check_update($sformatf("vec%0d", n), vecs[n], bc, da, dc, wc);
        end

        // Reset during the first shift write of a rank-0 insert: no write may land.
        load_table(base);
        @(negedge Clk);
        score = 1000;
        state = 3'b011;
        wc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            if (ram_we) begin
                wc = 1;
                break;
            end
        end
        checkOutput("reached SHIFT_WR", 64'(wc), 64'd1);
        Reset_n = 1'b0;
        #1;
        checkOutput("async reset busy", 64'(busy), 64'd0);
        checkOutput("async reset ram_we", 64'(ram_we), 64'd0);
        checkOutput("async reset done", 64'(done), 64'd0);
        checkOutput("async reset qualified", 64'(qualified), 64'd0);
        state = 3'b000;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        checkOutput("post reset idle", 64'(busy), 64'd0);
        check_table("post reset", base);
        applyStimulus(400, bc, da, dc, wc);
        check_update("after reset", vecs[0], bc, da, dc, wc);

        // Holding DONE must not retrigger; leaving and re-entering gives a second update.
        load_table(base);
        starts    = 0;
        dones     = 0;
        prev_busy = 1'b0;
        @(negedge Clk);
        score = 400;
        state = 3'b011;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clk);
            if (busy && !prev_busy) starts++;
            if (done) dones++;
            prev_busy = busy;
        end
        state = 3'b000;
        repeat (3) @(negedge Clk);
        score = 50;
        state = 3'b011;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            if (busy && !prev_busy) starts++;
            if (done) dones++;
            prev_busy = busy;
        end
        state = 3'b000;
        @(negedge Clk);
        checkOutput("held DONE updates", 64'(starts), 64'd2);
        checkOutput("held DONE done pulses", 64'(dones), 64'd2);
        checkOutput("held DONE qualified", 64'(qualified), 64'd0);
        check_table("held DONE", tbl(900, 500, 400, 300));

`ifdef HS_CLEAR_EN
        load_table(base);
        bc = 0;
        dc = 0;
        wc = 0;
        @(negedge Clk);
        clear = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            clear = 1'b0;
            if (ram_we) wc++;
            if (done) dc++;
            if (busy) bc++;
            else break;
        end
        checkOutput("clear busy cycles", 64'(bc), 64'd5);
        checkOutput("clear writes", 64'(wc), 64'd4);
        checkOutput("clear done pulses", 64'(dc), 64'd1);
        checkOutput("clear qualified", 64'(qualified), 64'd0);
        check_table("clear", tbl(0, 0, 0, 0));
        applyStimulus(10, bc, da, dc, wc);
        checkOutput("after clear new_rank", 64'(new_rank), 64'd0);
        checkOutput("after clear qualified", 64'(qualified), 64'd1);
        checkOutput("after clear busy", 64'(bc), 64'd10);
        check_table("after clear", tbl(10, 0, 0, 0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
